// File: rtl/seg_scan_if.sv
// seg_scan_if: digit-writer load bus and scanned 7-segment display outputs
interface seg_scan_if;
  logic load;
  logic [39:0] digit_data;
  logic [7:0] dp_mask;
  logic [7:0] blink_mask;
  logic [7:0] seg_left;
  logic [7:0] seg_right;
  logic [7:0] seg_en;
  logic frame_sync;
  logic pending;
  modport master (
    output load, digit_data, dp_mask, blink_mask,
    input seg_left, seg_right, seg_en, frame_sync, pending
  );
  modport slave (
    input load, digit_data, dp_mask, blink_mask,
    output seg_left, seg_right, seg_en, frame_sync, pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered 8-digit hex decoder, 4-slot multiplexed scan with blanking and blink
module seg_scan_driver #(
  parameter int DIV = 100_000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_FRAMES = 125
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);
  localparam int W = $clog2(DIV);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [W-1:0] SHOW_END = W'(DIV - BLANK_CYC - 1);
  localparam logic [W-1:0] SLOT_END = W'(DIV - 1);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_FRAMES - 1);
  localparam logic [55:0] BLANK_BUF = {16'h0, {8{5'b10000}}};
  typedef enum logic {SHOW, BLANK} state_t;
  state_t state, state_n;
  logic [W-1:0] div_cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [55:0] act, pbuf, eff, in_buf;
  logic pend, phase_on, slot_end, wrap, fs;
  logic [BW-1:0] bcnt;
  logic [7:0] seg_l, seg_r, en, seg_l_n, seg_r_n, en_n;
  function automatic logic [7:0] digit_seg(input logic [55:0] b, input logic [2:0] k, input logic on);
    logic [4:0] d;
    logic [6:0] s;
    d = b[5*k +: 5];
    case (d[3:0])
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return (!on && b[48+k]) ? 8'h00 : {d[4] ? 7'h00 : s, b[40+k]};
  endfunction
  assign in_buf = {bus.blink_mask, bus.dp_mask, bus.digit_data};
  assign slot_end = state == BLANK && div_cnt == SLOT_END;
  assign wrap = slot_end && idx == 2'd3;
  // a load landing on the frame_sync cycle must reach the very first SHOW cycle of the frame
  assign eff = fs && bus.load ? in_buf : act;
  assign bus.seg_left = seg_l;
  assign bus.seg_right = seg_r;
  assign bus.seg_en = en;
  assign bus.frame_sync = fs;
  assign bus.pending = pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW;
      div_cnt <= '0;
      idx <= '0;
      seg_l <= '0;
      seg_r <= '0;
      en <= '0;
      fs <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= cnt_n;
      idx <= idx_n;
      seg_l <= seg_l_n;
      seg_r <= seg_r_n;
      en <= en_n;
      fs <= wrap;
    end
  end
  always_comb begin
    state_n = state == SHOW ? (div_cnt == SHOW_END ? BLANK : SHOW) : (slot_end ? SHOW : BLANK);
    cnt_n = slot_end ? '0 : div_cnt + 1'b1;
    idx_n = slot_end ? idx + 2'd1 : idx;
  end
  always_comb begin
    en_n = state == SHOW ? 8'h11 << idx : 8'h00;
    seg_r_n = state == SHOW ? digit_seg(eff, {1'b0, idx}, phase_on) : 8'h00;
    seg_l_n = state == SHOW ? digit_seg(eff, {1'b1, idx}, phase_on) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= BLANK_BUF;
      pbuf <= '0;
      pend <= 1'b0;
      bcnt <= '0;
      phase_on <= 1'b1;
    end else if (wrap) begin
      if (pend) act <= pbuf;
      if (bus.load) pbuf <= in_buf;
      pend <= bus.load;
      bcnt <= bcnt == BLINK_END ? '0 : bcnt + 1'b1;
      if (bcnt == BLINK_END) phase_on <= ~phase_on;
    end else if (fs && bus.load) begin
      act <= in_buf;
      pend <= 1'b0;
    end else if (bus.load) begin
      pbuf <= in_buf;
      pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random loads checked cycle by cycle against a frame-arithmetic model
module tb_seg_scan_driver;
  localparam int DIV = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FR = 4 * DIV;
  localparam logic [55:0] BLANK_BUF = {16'h0, {8{5'b10000}}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg_scan_if bus();
  seg_scan_driver #(.DIV(DIV), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  int c = 0;
  logic [55:0] act, pbuf;
  bit pend;
  logic [7:0] e_r, e_l, e_en;
  bit e_fs;
  logic [7:0] hx [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                         8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, c, got, exp);
    end
  endtask
  function automatic logic [7:0] pat(logic [55:0] b, int k, bit on);
    logic [4:0] d;
    d = b[5*k +: 5];
    if (!on && b[48+k]) return 8'h00;
    return (d[4] ? 8'h00 : hx[d[3:0]]) | {7'b0, b[40+k]};
  endfunction
  // check the current cycle, drive inputs for the coming edge, predict the next cycle
  task automatic tick(bit r, bit ld, logic [55:0] d);
    int s;
    bit on, fs, show;
    logic [55:0] eff;
    chk("seg_en", bus.seg_en, e_en);
    chk("seg_right", bus.seg_right, e_r);
    chk("seg_left", bus.seg_left, e_l);
    chk("frame_sync", bus.frame_sync, e_fs);
    chk("pending", bus.pending, pend);
    rst = r;
    bus.load = ld;
    {bus.blink_mask, bus.dp_mask, bus.digit_data} = d;
    if (r) begin
      act = BLANK_BUF;
      pbuf = '0;
      pend = 0;
      {e_r, e_l, e_en} = '0;
      e_fs = 0;
      c = 0;
    end else begin
      fs = c > 0 && c % FR == 0;
      s = (c / DIV) % 4;
      on = ((c / FR) / BF) % 2 == 0;
      show = c % DIV < DIV - BC;
      eff = (fs && ld) ? d : act;
      e_en = show ? 8'((1 << s) | (1 << (s + 4))) : 8'h00;
      e_r = show ? pat(eff, s, on) : 8'h00;
      e_l = show ? pat(eff, s + 4, on) : 8'h00;
      e_fs = (c + 1) % FR == 0;
      if ((c + 1) % FR == 0) begin
        if (pend) act = pbuf;
        if (ld) pbuf = d;
        pend = ld;
      end else if (fs && ld) begin
        act = d;
        pend = 0;
      end else if (ld) begin
        pbuf = d;
        pend = 1;
      end
      c++;
    end
    @(negedge clk);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0);
  endtask
  task automatic wait_to(int k);
    for (int i = 0; i < FR && c % FR != k; i++) tick(0, 0, '0);
  endtask
  function automatic logic [55:0] all_digits(logic [4:0] v);
    return {16'h0, {8{v}}};
  endfunction
  function automatic logic [55:0] rnd_buf();
    logic [55:0] b;
    b[55:40] = 16'($urandom);
    for (int k = 0; k < 8; k++) b[5*k +: 5] = {$urandom_range(3) == 0, 4'($urandom)};
    return b;
  endfunction
  initial begin
    logic [55:0] d;
    bus.load = 0;
    bus.digit_data = '0;
    bus.dp_mask = '0;
    bus.blink_mask = '0;
    act = BLANK_BUF;
    pbuf = '0;
    pend = 0;
    {e_r, e_l, e_en} = '0;
    e_fs = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick(1, 0, '0);
    idle(40);
    d = '0;
    for (int k = 0; k < 8; k++) d[5*k +: 5] = 5'(8 - k);
    wait_to(6);
    tick(0, 1, d);
    idle(80);
    wait_to(5);
    tick(0, 1, all_digits(5'h00));
    wait_to(20);
    tick(0, 1, all_digits(5'h08));
    idle(70);
    wait_to(0);
    tick(0, 1, all_digits(5'h0A));
    idle(40);
    d = {8'h01, 8'h01, {7{5'b10000}}, 5'h05};
    wait_to(10);
    tick(0, 1, d);
    idle(6 * FR);
    for (int i = 0; i < 600; i++) tick(0, $urandom_range(19) == 0, rnd_buf());
    wait_to(2);
    tick(0, 1, all_digits(5'h03));
    tick(1, 0, '0);
    idle(100);
    for (int i = 0; i < 300; i++) tick(0, $urandom_range(9) == 0, rnd_buf());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
